mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for mem_ack before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port req, input, 1, CPU access request, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1, store when 1, load when 0.
REQ-006 SHALL have port op, input, 3, access size and sign: 000 word; 001 byte unsigned; 010 byte signed; 011 half unsigned; 100 half signed; 101-111 illegal.
REQ-007 SHALL have port addr, input, 32, byte address.
REQ-008 SHALL have port wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have ports mem_req, mem_we and mem_ack: out/out/in, 1 bit each, the memory bus handshake.
REQ-010 SHALL have ports mem_addr (out, 32, word address with [1:0]=00), mem_be (out, 4, byte enables) and mem_wdata (out, 32, lane-shifted store data).
REQ-011 SHALL have port mem_rdata, input, 32, raw read word, valid in the mem_ack cycle.
REQ-012 SHALL have port rdata, output, 32, extended load result, held until the next accepted load.
REQ-013 SHALL have ports done and err: outputs, 1 bit each, one-cycle completion pulse and one-cycle fault pulse.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, with the error path IDLE/ACCESS -> FAULT -> IDLE.
REQ-016 SHALL, in IDLE with req=1, latch we/op/addr/wdata and go to ACCESS, or go to FAULT when the access is misaligned or op is illegal.
REQ-017 SHALL treat an access as misaligned when it is a half access with addr[0]=1 or a word access with addr[1:0]!=00; byte accesses are never misaligned.
REQ-018 SHALL, in ACCESS, hold mem_req=1 with stable addr/be/wdata/we until mem_ack=1, then go to RESP on the next edge.
REQ-019 SHALL drive mem_be as follows: word 1111; half 0011 when addr[1]=0, 1100 when addr[1]=1; byte one-hot at bit addr[1:0].
REQ-020 SHALL build mem_wdata by replicating wdata[7:0] across all 4 lanes for byte stores, wdata[15:0] across both halves for half stores, and passing wdata unchanged for word stores.
REQ-021 SHALL, on the mem_ack cycle of a load, register the byte or half lane selected by addr into rdata, zero- or sign-extended per op.
REQ-022 SHALL pulse done for exactly one cycle in RESP for both loads and stores, and leave rdata unchanged on stores.
REQ-023 SHALL, in FAULT, pulse err for one cycle with mem_req=0 and then return to IDLE; a faulting access never reaches memory.
REQ-024 SHALL give a minimum latency from req accept to done of 3 cycles (ack in the first ACCESS cycle).
REQ-025 SHALL ignore req outside IDLE (no queuing) and ignore mem_ack outside ACCESS.
REQ-026 SHALL, when req is high in the same cycle as done, accept it only after returning to IDLE (next cycle).

Reset
REQ-027 SHALL, while rst_n=0, immediately force state IDLE and drive mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0 and busy=0.
REQ-028 SHALL, when reset asserts mid-ACCESS, drop mem_req and produce no done or err pulse for the aborted access.

Configuration
REQ-029 SHALL, with MEM_ACCESS_TIMEOUT_EN defined, count cycles spent in ACCESS and, when the count reaches TIMEOUT_CYCLES without mem_ack, deassert mem_req and go to FAULT; mem_ack on the same cycle as expiry wins.
REQ-030 SHALL, without MEM_ACCESS_TIMEOUT_EN, have no counter and wait in ACCESS indefinitely.

Structure
REQ-031 SHALL take the op encodings, the FSM state typedef and the byte-enable constants from shared package mem_ctrl_pkg.
REQ-032 SHALL place the lane select and extension logic in one combinational sub-module, ld_lane_ext (inputs addr[1:0], op, mem_rdata; output extended word).

Verification
REQ-033 SHALL cover: lb with addr=0x1003 and mem_rdata=0x80FF_FF00, ack after 2 wait cycles -> mem_be=1000, mem_addr=0x1000, rdata=0xFFFF_FF80, done 1 cycle.
REQ-034 SHALL cover: sh with addr=0x2002 and wdata=0x0000_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, done with rdata unchanged.
REQ-035 SHALL cover: lw with addr=0x0006 -> err pulse, mem_req never high, busy returns low after 2 cycles.
REQ-036 SHALL cover: op=110 with req -> err pulse and no bus activity.
REQ-037 SHALL cover: rst_n low during ACCESS -> mem_req=0 immediately, no done or err, state IDLE.
REQ-038 SHALL cover, with MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops after 4 ACCESS cycles, then err pulse.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller: op codes,
// FSM states, byte-enable constants and the alignment/lane helper functions.
package mem_ctrl_pkg;

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_BU   = 3'b001;
  localparam logic [2:0] OP_BS   = 3'b010;
  localparam logic [2:0] OP_HU   = 3'b011;
  localparam logic [2:0] OP_HS   = 3'b100;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  function automatic logic isHalf(input logic [2:0] op);
    return (op == OP_HU) || (op == OP_HS);
  endfunction

  function automatic logic isByte(input logic [2:0] op);
    return (op == OP_BU) || (op == OP_BS);
  endfunction

  // Illegal op codes and misaligned half/word accesses never reach the bus.
  function automatic logic isBadAccess(input logic [2:0] op, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    if (op > OP_HS) bad = 1'b1;
    else if (isHalf(op) && addrLo[0]) bad = 1'b1;
    else if ((op == OP_WORD) && (addrLo != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byteEnables(input logic [2:0] op, input logic [1:0] addrLo);
    logic [3:0] be;
    be = BE_WORD;
    if (isHalf(op)) be = addrLo[1] ? BE_HALF_HI : BE_HALF_LO;
    else if (isByte(op)) be = BE_BYTE0 << addrLo;
    return be;
  endfunction

  function automatic logic [31:0] laneStoreData(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    if (isByte(op)) d = {4{wdata[7:0]}};
    else if (isHalf(op)) d = {2{wdata[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/ld_lane_ext.sv
// Load path: picks the byte/half lane addressed by addr[1:0] out of the raw
// memory word and zero- or sign-extends it according to op.
module ld_lane_ext
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      OP_BU: o_data = {24'd0, w_byte};
      OP_BS: o_data = {{24{w_byte[7]}}, w_byte};
      OP_HU: o_data = {16'd0, w_half};
      OP_HS: o_data = {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller driving a single-beat memory handshake.
// Define MEM_ACCESS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without mem_ack.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_we;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] w_ldData;
  logic        w_inAccess;
  logic        w_timeout;

  assign w_inAccess = (r_state == ST_ACCESS);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_toCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_toCount <= '0;
    else if (!w_inAccess) r_toCount <= '0;
    else r_toCount <= r_toCount + CNT_W'(1);
  end

  // Counter holds the number of ACCESS cycles already spent, so expiry is the last allowed one.
  assign w_timeout = (r_toCount == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_nextState = isBadAccess(op, addr[1:0]) ? ST_FAULT : ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack) w_nextState = ST_RESP;
        else if (w_timeout) w_nextState = ST_FAULT;
      end
      ST_RESP:   w_nextState = ST_IDLE;
      ST_FAULT:  w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_op    <= OP_WORD;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == ST_IDLE) && req) begin
      r_we    <= we;
      r_op    <= op;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  ld_lane_ext u_ld_lane_ext (
    .i_addr  (r_addr[1:0]),
    .i_op    (r_op),
    .i_rdata (mem_rdata),
    .o_data  (w_ldData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else if (w_inAccess && mem_ack && !r_we) r_rdata <= w_ldData;
  end

  // Bus outputs are gated by ACCESS so faults and idle cycles show a quiet bus.
  always_comb begin
    mem_req   = w_inAccess;
    mem_we    = w_inAccess & r_we;
    mem_addr  = w_inAccess ? {r_addr[31:2], 2'b00} : 32'd0;
    mem_be    = w_inAccess ? byteEnables(r_op, r_addr[1:0]) : BE_NONE;
    mem_wdata = w_inAccess ? laneStoreData(r_op, r_wdata) : 32'd0;
  end

  assign rdata = r_rdata;
  assign done  = (r_state == ST_RESP);
  assign err   = (r_state == ST_FAULT);
  assign busy  = (r_state != ST_IDLE);

endmodule
